// File: rtl/param_datamem.sv
// param_datamem -- single-port word memory with registered read data and
// out-of-range detection.
//
// Optional feature macro: DMEM_INIT_EN
//   defined   : after reset release an INIT sweep writes mem[i] = i (mod
//               2^DATA_W), one word per cycle; ready rises once the sweep ends.
//   undefined : no INIT state and no sweep; ready rises on the first edge
//               after reset release and memory starts undefined.
//
// Parameters: DATA_W (word width), ADDR_W (address width), DEPTH (words).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   access request, accepted when ready is high
//   we        in   1 = write, 0 = read
//   addr      in   word address
//   wdata     in   write data
//   ready     out  a request can be accepted this cycle
//   rdata     out  read data, held until the next accepted read
//   rvalid    out  one-cycle pulse after each accepted read
//   err       out  one-cycle pulse after an accepted out-of-range access
//   init_done out  initialisation complete

module param_datamem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              init_done
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign accept   = req & ready;
  // One extra bit so DEPTH == 2^ADDR_W is representable.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

`ifdef DMEM_INIT_EN
  localparam int WIDE_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] init_cnt;

  // Sweep value: index reduced modulo 2^DATA_W (zero-extend or truncate).
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(idx);
    return wide[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_cnt == ADDR_W'(DEPTH - 1)) state_next = IDLE;
  end

  always_comb begin
    ready     = (state == IDLE);
    init_done = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              init_cnt <= '0;
    else if (state == INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // The sweep owns the write port while in INIT. While reset is held the
  // sweep keeps rewriting word 0 with its sweep value, which is harmless.
  always_comb begin
    mem_we    = accept & we & in_range;
    mem_addr  = addr;
    mem_wdata = wdata;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_cnt;
      mem_wdata = init_word(init_cnt);
    end
  end
`else
  logic live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign ready     = live;
  assign init_done = live;

  always_comb begin
    mem_we    = accept & we & in_range;
    mem_addr  = addr;
    mem_wdata = wdata;
  end
`endif

  // Storage: never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Response stage: one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= accept & ~we;
      err    <= accept & ~in_range;
      if (accept & ~we) rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_param_datamem.sv
// Self-checking bench for param_datamem. A default-sized instance is checked
// cycle by cycle against a scoreboard; a DEPTH=200 instance sharing the same
// inputs exercises out-of-range handling.

module tb_param_datamem;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int DEPTH       = 256;
  localparam int SMALL_DEPTH = 200;
`ifdef DMEM_INIT_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              req   = 1'b0;
  logic              we    = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [DATA_W-1:0] wdata = '0;

  logic              ready, rvalid, err, init_done;
  logic [DATA_W-1:0] rdata;
  logic              s_ready, s_rvalid, s_err, s_init_done;
  logic [DATA_W-1:0] s_rdata;

  param_datamem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err), .init_done(init_done)
  );

  param_datamem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(SMALL_DEPTH)) dut_small (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(s_ready), .rdata(s_rdata), .rvalid(s_rvalid), .err(s_err), .init_done(s_init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rv;
    logic              er;
    logic [DATA_W-1:0] rd;
    int                due;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] last_rd = '0;
  bit                exp_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every stepped cycle has one expected response, due one edge later.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (rvalid !== e.rv || err !== e.er || rdata !== e.rd) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d: rvalid=%b err=%b rdata=%h, expected rvalid=%b err=%b rdata=%h",
                 cyc, rvalid, err, rdata, e.rv, e.er, e.rd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drive one cycle of stimulus and record the expected response.
  task automatic step(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    exp_t e;
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d;
    e.rv = 1'b0; e.er = 1'b0; e.due = cyc + 1;
    if (r && exp_ready) begin
      if (int'(a) >= DEPTH) begin
        e.er = 1'b1;
        if (!w) begin e.rv = 1'b1; last_rd = '0; end
      end else if (w) begin
        exp_mem[a] = d;
      end else begin
        e.rv = 1'b1;
        last_rd = exp_mem[a];
      end
    end
    e.rd = last_rd;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic model_after_reset();
    last_rd = '0;
`ifdef DMEM_INIT_EN
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DATA_W'(i);
`endif
  endtask

  // Release is assumed done; count negedges until ready appears.
  task automatic wait_ready(input int expected);
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) break;
    end
    checks++;
    if (n != expected) begin
      errors++;
      $display("FAIL ready_latency: got %0d cycles, expected %0d", n, expected);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got %b, expected 1", init_done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({ready, init_done, rvalid, err} !== 4'b0000 || rdata !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b init_done=%b rvalid=%b err=%b rdata=%h, expected all 0",
               tag, ready, init_done, rvalid, err, rdata);
    end
    checks++;
    if ({s_ready, s_init_done, s_rvalid, s_err} !== 4'b0000 || s_rdata !== '0) begin
      errors++;
      $display("FAIL %s_small: ready=%b init_done=%b rvalid=%b err=%b rdata=%h, expected all 0",
               tag, s_ready, s_init_done, s_rvalid, s_err, s_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; addr = 8'h03;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    req = 1'b0;
  endtask

  task automatic test_init();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(INIT_CYCLES);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL small_ready: got %b, expected 1", s_ready);
    end
    model_after_reset();
    exp_ready = 1'b1;
  endtask

  task automatic test_first_access();
`ifdef DMEM_INIT_EN
    step(1'b1, 1'b0, 8'h03, '0);
    idle(1);
`endif
    step(1'b1, 1'b1, 8'h00, 8'h3C);
    step(1'b1, 1'b0, 8'h00, '0);
    idle(2);
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 8'h10, 8'hA5);
    step(1'b1, 1'b0, 8'h10, '0);
    idle(1);
    step(1'b1, 1'b1, 8'h11, 8'hFF);
    step(1'b1, 1'b0, 8'h11, '0);
    step(1'b1, 1'b1, 8'h12, 8'h80);
    step(1'b1, 1'b0, 8'h12, '0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i));
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, ADDR_W'(i), '0);
    idle(2);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, ADDR_W'(8'h20 + i), DATA_W'($urandom));
    for (int i = 0; i < 64; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ADDR_W'(8'h20 + $urandom_range(0, 31)), DATA_W'($urandom));
    idle(2);
  endtask

  task automatic test_out_of_range();
    step(1'b1, 1'b1, 8'hC7, 8'h9E);
    step(1'b1, 1'b1, 8'hC8, 8'h55);
    idle(1);
    checks++;
    if (s_err !== 1'b1 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: err=%b rvalid=%b, expected err=1 rvalid=0", s_err, s_rvalid);
    end
    step(1'b1, 1'b0, 8'hC7, '0);
    idle(1);
    checks++;
    if (s_err !== 1'b0 || s_rvalid !== 1'b1 || s_rdata !== 8'h9E) begin
      errors++;
      $display("FAIL inrange_read_c7: err=%b rvalid=%b rdata=%h, expected 0 1 9e", s_err, s_rvalid, s_rdata);
    end
    step(1'b1, 1'b0, 8'hC8, '0);
    idle(1);
    checks++;
    if (s_err !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== 8'h00) begin
      errors++;
      $display("FAIL oor_read: err=%b rvalid=%b rdata=%h, expected 1 1 00", s_err, s_rvalid, s_rdata);
    end
    idle(1);
    checks++;
    if (s_err !== 1'b0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_pulse_end: err=%b rvalid=%b, expected 0 0", s_err, s_rvalid);
    end
    step(1'b1, 1'b0, 8'hC7, '0);
    idle(1);
    checks++;
    if (s_rdata !== 8'h9E || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL c7_unchanged: rdata=%h rvalid=%b, expected 9e 1", s_rdata, s_rvalid);
    end
    step(1'b1, 1'b0, 8'hC8, '0);
    idle(2);
  endtask

  task automatic test_reset_abort();
    step(1'b1, 1'b0, 8'h10, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = 1'b0;
    sb.delete();
    exp_ready = 1'b0;
    last_rd = '0;
    #1;
    check_reset_outputs("abort_read");
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DMEM_INIT_EN
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check_reset_outputs("abort_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(DEPTH);
    model_after_reset();
    exp_ready = 1'b1;
    step(1'b1, 1'b0, 8'hFF, '0);
    step(1'b1, 1'b0, 8'h10, '0);
    idle(2);
`else
    wait_ready(1);
    model_after_reset();
    exp_ready = 1'b1;
    step(1'b1, 1'b0, 8'h10, '0);
    step(1'b1, 1'b0, 8'h00, '0);
    idle(2);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 'x;
    test_reset();
    test_init();
    test_first_access();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_reset_abort();
    idle(2);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
